// File: rtl/br_resolve_unit_if.sv
// EX-stage branch resolution bundle: operands and prediction in; redirect, kill and training out.
// Latency: wires only. Backpressure: none; EX freezes are signalled through i_stall.
// master = pipeline side driving EX state, slave = br_resolve_unit.
interface br_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic              i_valid_e;
    logic              i_stall;
    logic [31:0]       i_instr_e;
    logic [XLEN-1:0]   i_pc_e;
    logic [XLEN-1:0]   i_rs1_e;
    logic [XLEN-1:0]   i_rs2_e;
    logic [XLEN-1:0]   i_imm_e;
    logic              i_pred_taken_e;
    logic [XLEN-1:0]   i_pred_target_e;
    logic              o_redirect;
    logic [XLEN-1:0]   o_redirect_pc;
    logic              o_flush_if_id;
    logic              o_kill_e;
    logic              o_upd_valid;
    logic [XLEN-1:0]   o_upd_pc;
    logic              o_upd_taken;
    logic [XLEN-1:0]   o_upd_target;
    logic              o_upd_mispred;
    logic [CNT_W-1:0]  o_br_cnt;
    logic [CNT_W-1:0]  o_mispred_cnt;

    modport master (
        output i_valid_e, i_stall, i_instr_e, i_pc_e, i_rs1_e, i_rs2_e, i_imm_e,
               i_pred_taken_e, i_pred_target_e,
        input  o_redirect, o_redirect_pc, o_flush_if_id, o_kill_e, o_upd_valid,
               o_upd_pc, o_upd_taken, o_upd_target, o_upd_mispred, o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_valid_e, i_stall, i_instr_e, i_pc_e, i_rs1_e, i_rs2_e, i_imm_e,
               i_pred_taken_e, i_pred_target_e,
        output o_redirect, o_redirect_pc, o_flush_if_id, o_kill_e, o_upd_valid,
               o_upd_pc, o_upd_taken, o_upd_target, o_upd_mispred, o_br_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/br_resolve_unit.sv
// Resolves B-type (and JAL/JALR when JMP_EN) in EX, redirects on mispredict, trains the predictor.
// Latency: redirect/flush/update registered, one-cycle pulse at T+1; wrong-path EX slot killed until !i_stall.
// Backpressure: i_stall freezes resolution; optional counters under BRU_PERF_CNT_EN.
module br_resolve_unit #(
    parameter int XLEN   = 32,
    parameter int JMP_EN = 1,
    parameter int CNT_W  = 32
) (
    input logic              i_clk,
    input logic              i_rst_n,
    br_resolve_unit_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {ST_IDLE, ST_KILL} state_t;
    state_t state_q, state_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            eq, lt_s, lt_u;
    logic            is_ctrl, taken, mispred;
    logic            fire, resolve, kill_e;
    logic [XLEN-1:0] pc_imm, pc_plus4, jalr_sum, target, corr_pc;
    logic            unused_instr_bits;

    logic            redirect_q, upd_valid_q, upd_taken_q, upd_mispred_q;
    logic [XLEN-1:0] redirect_pc_q, upd_pc_q, upd_target_q;

    assign opcode   = bus.i_instr_e[6:0];
    assign funct3   = bus.i_instr_e[14:12];
    assign unused_instr_bits = ^{bus.i_instr_e[31:15], bus.i_instr_e[11:7]};

    assign eq       = (bus.i_rs1_e == bus.i_rs2_e);
    assign lt_s     = ($signed(bus.i_rs1_e) < $signed(bus.i_rs2_e));
    assign lt_u     = (bus.i_rs1_e < bus.i_rs2_e);
    assign pc_imm   = bus.i_pc_e + bus.i_imm_e;
    assign pc_plus4 = bus.i_pc_e + XLEN'(4);
    assign jalr_sum = bus.i_rs1_e + bus.i_imm_e;

    always_comb begin
        is_ctrl = 1'b0;
        taken   = 1'b0;
        target  = pc_imm;
        case (opcode)
            OP_BRANCH: begin
                is_ctrl = 1'b1;
                case (funct3)
                    3'b000:  taken = eq;
                    3'b001:  taken = !eq;
                    3'b100:  taken = lt_s;
                    3'b101:  taken = !lt_s;
                    3'b110:  taken = lt_u;
                    3'b111:  taken = !lt_u;
                    default: is_ctrl = 1'b0;
                endcase
            end
            OP_JAL: begin
                if (JMP_EN != 0) begin
                    is_ctrl = 1'b1;
                    taken   = 1'b1;
                end
            end
            OP_JALR: begin
                if (JMP_EN != 0) begin
                    is_ctrl = 1'b1;
                    taken   = 1'b1;
                    target  = {jalr_sum[XLEN-1:1], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // A right direction with a wrong BTB target still costs a redirect.
    assign mispred = (taken != bus.i_pred_taken_e) |
                     (taken & bus.i_pred_taken_e & (target != bus.i_pred_target_e));
    assign corr_pc = taken ? target : pc_plus4;

    assign fire    = bus.i_valid_e & !bus.i_stall & !kill_e;
    assign resolve = fire & is_ctrl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // The wrong-path slot leaves EX on the first unstalled cycle, valid or bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (resolve && mispred) state_d = ST_KILL;
            ST_KILL: if (!bus.i_stall)       state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kill_e = 1'b0;
        if (state_q == ST_KILL) kill_e = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            upd_mispred_q <= 1'b0;
        end else begin
            redirect_q  <= resolve & mispred;
            upd_valid_q <= resolve;
            if (resolve) begin
                redirect_pc_q <= corr_pc;
                upd_pc_q      <= bus.i_pc_e;
                upd_taken_q   <= taken;
                upd_target_q  <= target;
                upd_mispred_q <= mispred;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, mispred_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (resolve) begin
            if (br_cnt_q != {CNT_W{1'b1}})
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispred && (mispred_cnt_q != {CNT_W{1'b1}}))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_br_cnt      = br_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;
`else
    assign bus.o_br_cnt      = '0;
    assign bus.o_mispred_cnt = '0;
`endif

    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_flush_if_id = redirect_q;
    assign bus.o_kill_e      = kill_e;
    assign bus.o_upd_valid   = upd_valid_q;
    assign bus.o_upd_pc      = upd_pc_q;
    assign bus.o_upd_taken   = upd_taken_q;
    assign bus.o_upd_target  = upd_target_q;
    assign bus.o_upd_mispred = upd_mispred_q;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: scoreboard of expected training packets checked at T+1,
// plus per-scenario inline checks of redirect, kill and counters (BRU_PERF_CNT_EN aware).
module tb_br_resolve_unit;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    br_resolve_unit_if #(.XLEN(32), .CNT_W(4)) bus ();
    br_resolve_unit #(.XLEN(32), .JMP_EN(1), .CNT_W(4)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        ctrl;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] rpc;
        int          due;
    } sb_t;

    sb_t  q[$];
    sb_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic m_kill = 1'b0;

    localparam logic [31:0] JAL_I  = 32'h0000_006F;
    localparam logic [31:0] JALR_I = 32'h0000_0067;
    localparam logic [31:0] ALU_I  = 32'h0000_0033;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] br(input logic [2:0] f3);
        return {17'd0, f3, 5'd0, 7'b1100011};
    endfunction

    function automatic sb_t model(input logic [31:0] ins, pc, rs1, rs2, imm,
                                  input logic pt, input logic [31:0] ptg);
        sb_t e;
        e.ctrl = 1'b0; e.taken = 1'b0; e.pc = pc; e.tgt = pc + imm; e.due = 0;
        if (ins[6:0] == 7'b1100011) begin
            e.ctrl = 1'b1;
            case (ins[14:12])
                3'd0: e.taken = (rs1 == rs2);
                3'd1: e.taken = (rs1 != rs2);
                3'd4: e.taken = ($signed(rs1) < $signed(rs2));
                3'd5: e.taken = ($signed(rs1) >= $signed(rs2));
                3'd6: e.taken = (rs1 < rs2);
                3'd7: e.taken = (rs1 >= rs2);
                default: e.ctrl = 1'b0;
            endcase
        end else if (ins[6:0] == 7'b1101111) begin
            e.ctrl = 1'b1; e.taken = 1'b1;
        end else if (ins[6:0] == 7'b1100111) begin
            e.ctrl = 1'b1; e.taken = 1'b1; e.tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        end
        e.mis = (e.taken != pt) || (e.taken && pt && (e.tgt != ptg));
        e.rpc = e.taken ? e.tgt : pc + 32'd4;
        return e;
    endfunction

    // One EX cycle: drive, predict, push, clock; returns 1 time unit after the edge.
    task automatic issue(input logic v, input logic st, input logic [31:0] ins, pc, rs1, rs2, imm,
                         input logic pt, input logic [31:0] ptg);
        sb_t e;
        bus.i_valid_e = v; bus.i_stall = st; bus.i_instr_e = ins; bus.i_pc_e = pc;
        bus.i_rs1_e = rs1; bus.i_rs2_e = rs2; bus.i_imm_e = imm;
        bus.i_pred_taken_e = pt; bus.i_pred_target_e = ptg;
        e = model(ins, pc, rs1, rs2, imm, pt, ptg);
        if (v && !st && !m_kill && e.ctrl) begin
            e.due = cyc + 1;
            q.push_back(e);
        end
        if (m_kill) m_kill = st;
        else        m_kill = v & !st & e.ctrl & e.mis;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Scoreboard side: every training pulse must match the head entry and be due this cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (bus.o_upd_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL upd_unexpected: got upd pc=%h, required no update", bus.o_upd_pc);
                end else begin
                    mon_e = q.pop_front();
                    if (bus.o_upd_pc !== mon_e.pc || bus.o_upd_taken !== mon_e.taken ||
                        bus.o_upd_target !== mon_e.tgt || bus.o_upd_mispred !== mon_e.mis ||
                        bus.o_redirect !== mon_e.mis || bus.o_flush_if_id !== mon_e.mis ||
                        (mon_e.mis && bus.o_redirect_pc !== mon_e.rpc) || cyc != mon_e.due) begin
                        n_err++;
                        $display("FAIL upd_packet: got pc=%h tk=%b tgt=%h mis=%b rd=%b fl=%b rpc=%h cyc=%0d, required pc=%h tk=%b tgt=%h mis=%b rpc=%h cyc=%0d",
                                 bus.o_upd_pc, bus.o_upd_taken, bus.o_upd_target, bus.o_upd_mispred,
                                 bus.o_redirect, bus.o_flush_if_id, bus.o_redirect_pc, cyc,
                                 mon_e.pc, mon_e.taken, mon_e.tgt, mon_e.mis, mon_e.rpc, mon_e.due);
                    end
                end
            end else begin
                if (q.size() != 0 && q[0].due < cyc) begin
                    n_cmp++; n_err++;
                    $display("FAIL upd_missing: got no update, required pc=%h at cyc %0d", q[0].pc, q[0].due);
                    void'(q.pop_front());
                end
                if (bus.o_redirect || bus.o_flush_if_id) begin
                    n_cmp++; n_err++;
                    $display("FAIL redirect_spurious: got rd=%b fl=%b, required 0 without update",
                             bus.o_redirect, bus.o_flush_if_id);
                end
            end
        end
    end

    task automatic test_reset();
        bus.i_valid_e = 0; bus.i_stall = 0; bus.i_instr_e = 0; bus.i_pc_e = 0; bus.i_rs1_e = 0;
        bus.i_rs2_e = 0; bus.i_imm_e = 0; bus.i_pred_taken_e = 0; bus.i_pred_target_e = 0;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++;
        if (bus.o_redirect !== 1'b0 || bus.o_flush_if_id !== 1'b0 || bus.o_redirect_pc !== 32'd0) begin
            n_err++; $display("FAIL reset_redirect: got rd=%b fl=%b rpc=%h, required 0", bus.o_redirect, bus.o_flush_if_id, bus.o_redirect_pc);
        end
        n_cmp++;
        if (bus.o_upd_valid !== 1'b0 || bus.o_upd_pc !== 32'd0 || bus.o_upd_target !== 32'd0) begin
            n_err++; $display("FAIL reset_upd: got v=%b pc=%h tgt=%h, required 0", bus.o_upd_valid, bus.o_upd_pc, bus.o_upd_target);
        end
        n_cmp++;
        if (bus.o_kill_e !== 1'b0 || bus.o_br_cnt !== 4'd0 || bus.o_mispred_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_kill_cnt: got kill=%b br=%0d mis=%0d, required 0", bus.o_kill_e, bus.o_br_cnt, bus.o_mispred_cnt);
        end
        i_rst_n = 1'b1;
        m_kill = 1'b0;
        q.delete();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_correct_pred();
        issue(1, 0, br(3'd0), 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120);
        n_cmp++;
        if (bus.o_redirect !== 1'b0 || bus.o_kill_e !== 1'b0 || bus.o_upd_valid !== 1'b1 || bus.o_upd_target !== 32'h120) begin
            n_err++; $display("FAIL correct_pred: got rd=%b kill=%b v=%b tgt=%h, required 0 0 1 00000120",
                              bus.o_redirect, bus.o_kill_e, bus.o_upd_valid, bus.o_upd_target);
        end
        idle(1);
        n_cmp++;
        if (bus.o_kill_e !== 1'b0 || bus.o_upd_valid !== 1'b0) begin
            n_err++; $display("FAIL correct_pred_after: got kill=%b v=%b, required 0 0", bus.o_kill_e, bus.o_upd_valid);
        end
    endtask

    task automatic test_mispred_not_taken();
        issue(1, 0, br(3'd6), 32'h200, 32'd1, 32'hFFFF_FFFF, 32'h40, 0, 32'd0);
        n_cmp++;
        if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h240 || bus.o_flush_if_id !== 1'b1 || bus.o_kill_e !== 1'b1) begin
            n_err++; $display("FAIL mispred_nt_t1: got rd=%b rpc=%h fl=%b kill=%b, required 1 00000240 1 1",
                              bus.o_redirect, bus.o_redirect_pc, bus.o_flush_if_id, bus.o_kill_e);
        end
        idle(1);
        n_cmp++;
        if (bus.o_kill_e !== 1'b0 || bus.o_redirect !== 1'b0) begin
            n_err++; $display("FAIL mispred_nt_t2: got kill=%b rd=%b, required 0 0", bus.o_kill_e, bus.o_redirect);
        end
    endtask

    task automatic test_signed_unsigned();
        issue(1, 0, br(3'd5), 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1, 32'h310);
        n_cmp++;
        if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h304 || bus.o_upd_taken !== 1'b0) begin
            n_err++; $display("FAIL bge_signed: got rd=%b rpc=%h tk=%b, required 1 00000304 0",
                              bus.o_redirect, bus.o_redirect_pc, bus.o_upd_taken);
        end
        idle(1);
        issue(1, 0, br(3'd7), 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1, 32'h310);
        n_cmp++;
        if (bus.o_redirect !== 1'b0 || bus.o_upd_taken !== 1'b1 || bus.o_kill_e !== 1'b0) begin
            n_err++; $display("FAIL bgeu_unsigned: got rd=%b tk=%b kill=%b, required 0 1 0",
                              bus.o_redirect, bus.o_upd_taken, bus.o_kill_e);
        end
    endtask

    task automatic test_jumps();
        issue(1, 0, JALR_I, 32'h500, 32'h1001, 32'd0, 32'h10, 1, 32'h1010);
        n_cmp++;
        if (bus.o_redirect !== 1'b0 || bus.o_upd_target !== 32'h1010 || bus.o_upd_mispred !== 1'b0) begin
            n_err++; $display("FAIL jalr_hit: got rd=%b tgt=%h mis=%b, required 0 00001010 0",
                              bus.o_redirect, bus.o_upd_target, bus.o_upd_mispred);
        end
        issue(1, 0, JALR_I, 32'h504, 32'h2001, 32'd0, 32'h10, 1, 32'h1010);
        n_cmp++;
        if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h2010 || bus.o_upd_mispred !== 1'b1) begin
            n_err++; $display("FAIL jalr_target_miss: got rd=%b rpc=%h mis=%b, required 1 00002010 1",
                              bus.o_redirect, bus.o_redirect_pc, bus.o_upd_mispred);
        end
        idle(1);
        issue(1, 0, JAL_I, 32'h400, 32'd0, 32'd0, 32'h100, 0, 32'd0);
        n_cmp++;
        if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h500) begin
            n_err++; $display("FAIL jal_mispred: got rd=%b rpc=%h, required 1 00000500", bus.o_redirect, bus.o_redirect_pc);
        end
        idle(1);
    endtask

    task automatic test_stall_shadow();
        issue(1, 0, br(3'd0), 32'h700, 32'd1, 32'd2, 32'h8, 1, 32'h708);
        n_cmp++;
        if (bus.o_redirect !== 1'b1 || bus.o_kill_e !== 1'b1 || bus.o_redirect_pc !== 32'h704) begin
            n_err++; $display("FAIL shadow_t1: got rd=%b kill=%b rpc=%h, required 1 1 00000704",
                              bus.o_redirect, bus.o_kill_e, bus.o_redirect_pc);
        end
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, br(3'd0), 32'h704, 32'd3, 32'd3, 32'h8, 0, 32'd0);
            n_cmp++;
            if (bus.o_redirect !== 1'b0 || bus.o_kill_e !== 1'b1 || bus.o_upd_valid !== 1'b0) begin
                n_err++; $display("FAIL shadow_stall_%0d: got rd=%b kill=%b v=%b, required 0 1 0",
                                  i, bus.o_redirect, bus.o_kill_e, bus.o_upd_valid);
            end
        end
        issue(1, 0, br(3'd0), 32'h704, 32'd3, 32'd3, 32'h8, 0, 32'd0);
        n_cmp++;
        if (bus.o_kill_e !== 1'b0 || bus.o_upd_valid !== 1'b0 || bus.o_redirect !== 1'b0) begin
            n_err++; $display("FAIL shadow_exit: got kill=%b v=%b rd=%b, required 0 0 0",
                              bus.o_kill_e, bus.o_upd_valid, bus.o_redirect);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] ins, rs1, rs2, imm, pc, ptg;
        logic        pt, v, st;
        sb_t         e;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       ins = JAL_I;
                1:       ins = JALR_I;
                2:       ins = ALU_I;
                3:       ins = br(3'd2);
                default: ins = br(f3s[$urandom_range(0, 5)]);
            endcase
            rs1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            rs2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            imm = 32'($urandom_range(0, 255)) << 2;
            pc  = 32'h8000 + (32'(i) << 2);
            e   = model(ins, pc, rs1, rs2, imm, 1'b0, 32'd0);
            if ($urandom_range(0, 2) != 0) begin
                pt = e.taken; ptg = e.tgt;
            end else begin
                pt = 1'($urandom_range(0, 1)); ptg = pc + (32'($urandom_range(0, 3)) << 2);
            end
            v  = ($urandom_range(0, 5) != 0);
            st = ($urandom_range(0, 4) == 0);
            n_cmp++;
            if (bus.o_kill_e !== m_kill) begin
                n_err++; $display("FAIL b2b_kill_%0d: got kill=%b, required %b", i, bus.o_kill_e, m_kill);
            end
            issue(v, st, ins, pc, rs1, rs2, imm, pt, ptg);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_kill();
        issue(1, 0, br(3'd0), 32'h600, 32'd1, 32'd2, 32'h8, 1, 32'h608);
        #1;
        i_rst_n = 1'b0;
        q.delete();
        m_kill = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_redirect !== 1'b0 || bus.o_kill_e !== 1'b0 || bus.o_upd_valid !== 1'b0 || bus.o_flush_if_id !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_kill: got rd=%b kill=%b v=%b fl=%b, required 0 0 0 0",
                              bus.o_redirect, bus.o_kill_e, bus.o_upd_valid, bus.o_flush_if_id);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_counters();
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 10 || i == 15) begin
                issue(1, 0, br(3'd0), 32'h900, 32'd7, 32'd7, 32'h10, 0, 32'd0);
                idle(1);
            end else begin
                issue(1, 0, br(3'd0), 32'h900, 32'd7, 32'd7, 32'h10, 1, 32'h910);
            end
        end
        idle(1);
        n_cmp++;
`ifdef BRU_PERF_CNT_EN
        if (bus.o_br_cnt !== 4'd15 || bus.o_mispred_cnt !== 4'd3) begin
            n_err++; $display("FAIL counters: got br=%0d mis=%0d, required 15 3", bus.o_br_cnt, bus.o_mispred_cnt);
        end
`else
        if (bus.o_br_cnt !== 4'd0 || bus.o_mispred_cnt !== 4'd0) begin
            n_err++; $display("FAIL counters_off: got br=%0d mis=%0d, required 0 0", bus.o_br_cnt, bus.o_mispred_cnt);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_correct_pred();
        test_mispred_not_taken();
        test_signed_unsigned();
        test_jumps();
        test_stall_shadow();
        test_back_to_back();
        test_reset_mid_kill();
        test_counters();
        idle(2);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL sb_drain: got %0d pending updates, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
Parametrised execute-stage branch/jump resolution unit for the 5-stage RISC-V pipeline. It evaluates all B-type conditions internally and, when JMP_EN=1, also handles JAL/JALR. It compares the outcome against the front-end (agree) predictor's guess and issues a registered redirect plus a front-end flush on misprediction. It squashes the wrong-path instruction that enters EX during the redirect shadow and emits a registered training packet to the predictor.

Parameters:
XLEN, 32, datapath/PC width (32 or 64)
JMP_EN, 1, 1 = resolve JAL/JALR here; 0 = treat them as non-control (no resolve, no update)
CNT_W, 32, width of the performance counters (optional feature)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid_e  in  1  EX holds a real (non-bubble) instruction
i_stall  in  1  EX is frozen this cycle; nothing resolves
i_instr_e  in  32  EX instruction word
i_pc_e  in  XLEN  EX instruction PC
i_rs1_e  in  XLEN  forwarded rs1 value
i_rs2_e  in  XLEN  forwarded rs2 value
i_imm_e  in  XLEN  sign-extended B/J/I immediate
i_pred_taken_e  in  1  predictor's taken guess, carried down the pipe
i_pred_target_e  in  XLEN  predicted target (BTB)
o_redirect  out  1  one-cycle pulse: front end loads o_redirect_pc
o_redirect_pc  out  XLEN  corrected fetch PC
o_flush_if_id  out  1  clear the IF/ID register (equals o_redirect)
o_kill_e  out  1  squash the instruction currently in EX (no writeback, no resolve)
o_upd_valid  out  1  predictor training pulse
o_upd_pc  out  XLEN  PC of the resolved instruction
o_upd_taken  out  1  actual outcome
o_upd_target  out  XLEN  actual target
o_upd_mispred  out  1  resolution was a misprediction
o_br_cnt  out  CNT_W  resolved control-transfer count
o_mispred_cnt  out  CNT_W  misprediction count

Behaviour:
- Reset values: every output 0; FSM in IDLE; counters 0. Reset is asynchronous; reset asserted mid-redirect drops all pulses immediately.
- fire = i_valid_e & !i_stall & !o_kill_e. Resolution happens only when fire is high.
- Conditional branch (opcode 1100011):
  - beq: eq
  - bne: !eq
  - blt: signed lt
  - bge: !signed lt
  - bltu: unsigned lt
  - bgeu: !unsigned lt
  - funct3 010/011: treated as non-control, no update
  - target = pc+imm
- JAL (1101111): taken, target = pc+imm.
- JALR (1100111): taken, target = (rs1+imm) & ~1.
- All arithmetic is XLEN-bit, wrapping modulo 2^XLEN.
- mispred = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
- Corrected PC = taken ? target : pc+4.
- Latency: outcome at cycle T (fire) -> o_upd_* and o_redirect/o_redirect_pc/o_flush_if_id registered, visible at T+1 for exactly 1 cycle. o_upd_valid pulses for every resolved control instruction, mispredicted or not.
- FSM:
  - IDLE -> KILL on fire & mispred.
  - KILL: o_kill_e = 1 (combinational from state).
  - KILL -> IDLE on the first cycle with !i_stall, i.e. the wrong-path instruction has left EX.
  - KILL while i_stall = 1: stay in KILL, keep o_kill_e = 1. o_redirect is still a single pulse at T+1 and is never repeated.
- Simultaneous events:
  - A control instruction in EX during KILL is killed. It is not resolved, not counted, and generates no update.
  - i_valid_e = 0 in KILL still leaves KILL on !i_stall.
- Non-control instructions and bubbles produce no outputs.

Optional Feature:
BRU_PERF_CNT_EN
- Defined: o_br_cnt increments on each fire of a control instruction. o_mispred_cnt increments additionally when mispred. Both saturate at 2^CNT_W-1 and are cleared only by reset.
- Undefined: no counter flops; o_br_cnt and o_mispred_cnt are tied to 0.

Test Plan:
- Correct prediction: beq, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> T+1: upd_valid=1, upd_taken=1, upd_target=0x120, mispred=0; redirect=0; kill_e never 1.
- Mispredicted not-taken: bltu, rs1=1, rs2=0xFFFFFFFF, pc=0x200, imm=0x40, pred_taken=0 -> T+1: redirect=1, redirect_pc=0x240, flush_if_id=1, kill_e=1; T+2: kill_e=0.
- Signed vs unsigned: bge, rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pc=0x300 -> not taken, redirect_pc=0x304; the same operands with bgeu -> taken, no redirect.
- JALR target mismatch: rs1=0x1001, imm=0x10, pred_taken=1, pred_target=0x1010 -> target=0x1010, no mispred; with rs1=0x2001 -> redirect_pc=0x2010, upd_mispred=1.
- Stall in shadow: mispredict at T, i_stall=1 for T+1..T+3 -> redirect pulse only at T+1; kill_e=1 through T+4; a branch held in EX in that window generates no update; IDLE at T+5.
- Reset and counters: assert i_rst_n=0 during KILL -> all outputs 0 at once. With BRU_PERF_CNT_EN defined and CNT_W=4, 20 resolved branches with 3 mispredicts -> o_br_cnt=15 (saturated), o_mispred_cnt=3.
